// File: rtl/lsb_psel_gen_pkg.sv
// ============================================================================
// Module : lsb_psel_gen_pkg
// Brief  : Shared defaults for the lowest-index-first multi-grant selector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsb_psel_gen_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_DEFAULT_REQS  = 2;

endpackage : lsb_psel_gen_pkg

`default_nettype wire

// File: rtl/lsb_psel_single.sv
// ============================================================================
// Module : lsb_psel_single
// Brief  : One-hot grant of the lowest set request bit, plus an empty flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsb_psel_single #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic             empty
);

    // Two's-complement isolates the lowest set bit.
    assign gnt   = req & (~req + WIDTH'(1));
    assign empty = ~|req;

endmodule : lsb_psel_single

`default_nettype wire

// File: rtl/lsb_psel_gen.sv
// ============================================================================
// Module : lsb_psel_gen
// Brief  : Grants up to REQS requests lowest-index first; combinational grants
//          plus a one-cycle registered copy.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsb_psel_gen
    import lsb_psel_gen_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int REQS  = c_DEFAULT_REQS
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                req,
    output logic [WIDTH-1:0]                gnt,
    output logic [REQS-1:0][WIDTH-1:0]      gnt_bus,
    output logic                            empty,
    output logic [$clog2(REQS+1)-1:0]       num_gnt,
    output logic [WIDTH-1:0]                gnt_q,
    output logic [REQS-1:0][WIDTH-1:0]      gnt_bus_q
);

    localparam int c_NUM_W = $clog2(REQS+1);

    logic [REQS-1:0][WIDTH-1:0] w_stage_req;
    logic [REQS-1:0][WIDTH-1:0] w_stage_gnt;
    logic [REQS-1:0]            w_stage_empty;
    logic [WIDTH-1:0]           w_gnt;
    logic [c_NUM_W-1:0]         w_num_gnt;
    logic [WIDTH-1:0]           r_gnt_q;
    logic [REQS-1:0][WIDTH-1:0] r_gnt_bus_q;

    // Each stage sees the request with all earlier stages' grants removed.
    for (genvar k = 0; k < REQS; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_stage_req[k] = req;
        end else begin : g_rest
            assign w_stage_req[k] = w_stage_req[k-1] & ~w_stage_gnt[k-1];
        end

        lsb_psel_single #(
            .WIDTH (WIDTH)
        ) u_single (
            .req   (w_stage_req[k]),
            .gnt   (w_stage_gnt[k]),
            .empty (w_stage_empty[k])
        );
    end

    always_comb begin
        w_gnt     = '0;
        w_num_gnt = '0;
        for (int k = 0; k < REQS; k++) begin
            w_gnt     = w_gnt | w_stage_gnt[k];
            w_num_gnt = w_num_gnt + c_NUM_W'(~w_stage_empty[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt_q     <= '0;
            r_gnt_bus_q <= '0;
        end else begin
            r_gnt_q     <= w_gnt;
            r_gnt_bus_q <= w_stage_gnt;
        end
    end

    assign gnt       = w_gnt;
    assign gnt_bus   = w_stage_gnt;
    assign empty     = ~|req;
    assign num_gnt   = w_num_gnt;
    assign gnt_q     = r_gnt_q;
    assign gnt_bus_q = r_gnt_bus_q;

endmodule : lsb_psel_gen

`default_nettype wire

// File: tb/tb_lsb_psel_gen.sv
// ============================================================================
// Module : tb_lsb_psel_gen
// Brief  : Directed and random checks of lsb_psel_gen at WIDTH=20, REQS=2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsb_psel_gen;

    localparam int c_WIDTH = 20;
    localparam int c_REQS  = 2;

    logic                           clock;
    logic                           reset;
    logic [c_WIDTH-1:0]             req;
    logic [c_WIDTH-1:0]             gnt;
    logic [c_REQS-1:0][c_WIDTH-1:0] gnt_bus;
    logic                           empty;
    logic [1:0]                     num_gnt;
    logic [c_WIDTH-1:0]             gnt_q;
    logic [c_REQS-1:0][c_WIDTH-1:0] gnt_bus_q;

    int r_errors = 0;
    int r_checks = 0;

    lsb_psel_gen #(
        .WIDTH (c_WIDTH),
        .REQS  (c_REQS)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_bus   (gnt_bus),
        .empty     (empty),
        .num_gnt   (num_gnt),
        .gnt_q     (gnt_q),
        .gnt_bus_q (gnt_bus_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: walk bits upward, handing out slots until REQS are used.
    task automatic model(input logic [c_WIDTH-1:0] r,
                         output logic [c_WIDTH-1:0] m_gnt,
                         output logic [c_WIDTH-1:0] m_b0,
                         output logic [c_WIDTH-1:0] m_b1,
                         output int                 m_num);
        m_gnt = '0; m_b0 = '0; m_b1 = '0; m_num = 0;
        for (int i = 0; i < c_WIDTH; i++) begin
            if (r[i] && m_num < c_REQS) begin
                if (m_num == 0) m_b0[i] = 1'b1;
                else            m_b1[i] = 1'b1;
                m_gnt[i] = 1'b1;
                m_num++;
            end
        end
    endtask

    task automatic check_comb(input string tag, input logic [c_WIDTH-1:0] e_gnt,
                              input logic [c_WIDTH-1:0] e_b0, input logic [c_WIDTH-1:0] e_b1,
                              input logic e_empty, input int e_num);
        check({tag, ".gnt"},   32'(gnt),        32'(e_gnt));
        check({tag, ".bus0"},  32'(gnt_bus[0]), 32'(e_b0));
        check({tag, ".bus1"},  32'(gnt_bus[1]), 32'(e_b1));
        check({tag, ".empty"}, 32'(empty),      32'(e_empty));
        check({tag, ".num"},   32'(num_gnt),    32'(e_num));
    endtask

    initial begin
        logic [c_WIDTH-1:0] v_req, m_gnt, m_b0, m_b1;
        int                 m_num;

        reset = 1'b1;
        req   = '0;

        // Directed combinational vectors
        #1;
        check_comb("zero", 20'h00000, 20'h00000, 20'h00000, 1'b1, 0);
        req = 20'h00001; #1;
        check_comb("one",  20'h00001, 20'h00001, 20'h00000, 1'b0, 1);
        req = 20'h80010; #1;
        check_comb("two",  20'h80010, 20'h00010, 20'h80000, 1'b0, 2);
        req = 20'hFFFFF; #1;
        check_comb("full", 20'h00003, 20'h00001, 20'h00002, 1'b0, 2);
        req = 20'h80000; #1;
        check_comb("top",  20'h80000, 20'h80000, 20'h00000, 1'b0, 1);
        req = 20'hC0001; #1;
        check_comb("drop", 20'h40001, 20'h00001, 20'h40000, 1'b0, 2);

        // Registered path under reset
        req = 20'h00C00;
        @(posedge clock); @(posedge clock); #1;
        check("rst.gnt_q",  32'(gnt_q),        32'h0);
        check("rst.bus0_q", 32'(gnt_bus_q[0]), 32'h0);
        check("rst.bus1_q", 32'(gnt_bus_q[1]), 32'h0);

        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("reg.gnt_q",  32'(gnt_q),        32'h00C00);
        check("reg.bus0_q", 32'(gnt_bus_q[0]), 32'h00400);
        check("reg.bus1_q", 32'(gnt_bus_q[1]), 32'h00800);

        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst2.gnt_q",  32'(gnt_q),        32'h0);
        check("rst2.bus0_q", 32'(gnt_bus_q[0]), 32'h0);
        check("rst2.comb",   32'(gnt),          32'h00C00);

        @(negedge clock);
        reset = 1'b0;

        // Random vectors, mixing dense and sparse patterns
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            v_req = c_WIDTH'($urandom);
            if (n % 3 == 1) v_req = v_req & c_WIDTH'($urandom) & c_WIDTH'($urandom);
            if (n % 3 == 2) v_req = v_req & c_WIDTH'($urandom) & c_WIDTH'($urandom)
                                          & c_WIDTH'($urandom) & c_WIDTH'($urandom);
            req = v_req;
            model(v_req, m_gnt, m_b0, m_b1, m_num);
            #1;
            check_comb("rand", m_gnt, m_b0, m_b1, (v_req == '0), m_num);
            @(posedge clock); #1;
            check("rand.gnt_q",  32'(gnt_q),        32'(m_gnt));
            check("rand.bus0_q", 32'(gnt_bus_q[0]), 32'(m_b0));
            check("rand.bus1_q", 32'(gnt_bus_q[1]), 32'(m_b1));
        end

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule : tb_lsb_psel_gen

`default_nettype wire
